// File: rtl/alu_seq.sv
// Multi-cycle slice-serial ALU: AND/OR/ADD over WIDTH bits, SLICE bits per clock, valid/ready on both sides.
// Optional signed set-less-than on op 11 is enabled by defining ALU_SLT_EN; otherwise op 11 is ADD.
module alu_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SW     = SLICE + 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("alu_seq: SLICE must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
  logic             carry;
  logic             zacc;
  logic [KW-1:0]    k;

  logic             accept_c, step_c, last_c;
  logic [SLICE-1:0] a_s, b_s, sum_s, slice_v;
  logic [SLICE:0]   add_w;
  logic             c_nx, ovf_c, zacc_nx;
  logic [WIDTH-1:0] res_shift;
`ifdef ALU_SLT_EN
  logic             lt_c;
`endif

  // State register; handshake flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = BUSY;
      BUSY:    if (k == KLAST)           state_nx = DONE;
      DONE:    if (out_ready)            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE:    accept_c = in_valid && in_ready;
      BUSY: begin
        step_c = 1'b1;
        last_c = (k == KLAST);
      end
      default: ;
    endcase
  end

  // One slice of the operation; operands shift down so the active slice is always the LSBs
  always_comb begin
    a_s     = a_r[SLICE-1:0];
    b_s     = b_r[SLICE-1:0];
    add_w   = SW'(a_s) + SW'(b_s) + SW'(carry);
    sum_s   = add_w[SLICE-1:0];
    c_nx    = add_w[SLICE];
    ovf_c   = (a_s[SLICE-1] == b_s[SLICE-1]) && (sum_s[SLICE-1] != a_s[SLICE-1]);
    case (op_r)
      2'b00:   slice_v = a_s & b_s;
      2'b01:   slice_v = a_s | b_s;
      default: slice_v = sum_s;
    endcase
    zacc_nx   = zacc & (slice_v == '0);
    res_shift = (result >> SLICE) | (WIDTH'(slice_v) << (WIDTH - SLICE));
`ifdef ALU_SLT_EN
    lt_c      = sum_s[SLICE-1] ^ ovf_c;
`endif
  end

  // Operand, carry chain and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 2'b00;
      carry    <= 1'b0;
      zacc     <= 1'b0;
      k        <= '0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept_c) begin
      a_r   <= ainv ? ~a : a;
      b_r   <= binv ? ~b : b;
      op_r  <= op;
      carry <= cin;
      zacc  <= 1'b1;
      k     <= '0;
    end else if (step_c) begin
      a_r    <= a_r >> SLICE;
      b_r    <= b_r >> SLICE;
      carry  <= c_nx;
      zacc   <= zacc_nx;
      k      <= k + KW'(1);
      result <= res_shift;
      if (last_c) begin
        cout     <= c_nx;
        overflow <= ovf_c;
        zero     <= zacc_nx;
`ifdef ALU_SLT_EN
        if (op_r == 2'b11) begin
          result <= WIDTH'(lt_c);
          zero   <= ~lt_c;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, randomized ops against a wide-arithmetic model,
// backpressure, mid-operation reset and back-to-back throughput. A 16/16 instance covers NSLICE==1.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, ainv, binv, cin, out_ready;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        in_ready, out_valid, cout, zero, overflow;
  logic [63:0] result;
  logic        n_in_ready, n_out_valid, n_cout, n_zero, n_overflow;
  logic [15:0] n_result;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(64), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ainv(ainv), .binv(binv), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .overflow(overflow)
  );

  alu_seq #(.WIDTH(16), .SLICE(16)) ndut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .a(a[15:0]), .b(b[15:0]), .ainv(ainv), .binv(binv), .cin(cin), .op(op),
    .out_valid(n_out_valid), .out_ready(out_ready), .result(n_result),
    .cout(n_cout), .zero(n_zero), .overflow(n_overflow)
  );

  // Reference: true signed sum in 66 bits decides overflow and less-than
  function automatic void model(input logic [63:0] ta, input logic [63:0] tb, input logic ai,
                                input logic bi, input logic ci, input logic [1:0] top,
                                output logic [63:0] r, output logic co, output logic z,
                                output logic ov);
    logic [63:0]        av, bv;
    logic [64:0]        u;
    logic signed [65:0] s;
    av = ai ? ~ta : ta;
    bv = bi ? ~tb : tb;
    u  = {1'b0, av} + {1'b0, bv} + 65'(ci);
    s  = $signed({{2{av[63]}}, av}) + $signed({{2{bv[63]}}, bv}) + $signed(66'(ci));
    ov = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
    co = u[64];
    case (top)
      2'b00: r = av & bv;
      2'b01: r = av | bv;
      2'b10: r = u[63:0];
`ifdef ALU_SLT_EN
      default: r = 64'(s < 0);
`else
      default: r = u[63:0];
`endif
    endcase
    z = (r == 64'd0);
  endfunction

  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb, input logic ai,
                          input logic bi, input logic ci, input logic [1:0] top);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL start_op_ready in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    a = ta; b = tb; ainv = ai; binv = bi; cin = ci; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
    ainv = 1'($urandom()); binv = 1'($urandom()); cin = 1'($urandom()); op = 2'($urandom());
  endtask

  task automatic wait_done(output int lat, output int nlat);
    lat = 0; nlat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (n_out_valid && nlat == 0) nlat = lat;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL wait_done_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic release_op();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, cout, zero, overflow} !== 5'b10000 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_values rdy=%b vld=%b res=%h c=%b z=%b o=%b required rdy=1 vld=0 res=0 flags=0",
               in_ready, out_valid, result, cout, zero, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    int lat, nlat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 2'b10);
    wait_done(lat, nlat);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL add_wrap_latency got %0d required 8", lat); end
    checks++;
    if (result !== 64'd0 || {cout, zero, overflow} !== 3'b110) begin
      errors++; $display("FAIL add_wrap res=%h c=%b z=%b o=%b required 0 1 1 0", result, cout, zero, overflow);
    end
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL add_wrap_release rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_sub();
    int lat, nlat;
    start_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b1, 2'b10);
    wait_done(lat, nlat);
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFE || {cout, zero, overflow} !== 3'b000) begin
      errors++; $display("FAIL sub res=%h c=%b z=%b o=%b required fffffffffffffffe 0 0 0", result, cout, zero, overflow);
    end
    release_op();
  endtask

  task automatic test_overflow();
    int lat, nlat;
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 2'b10);
    wait_done(lat, nlat);
    checks++;
    if (result !== 64'h8000_0000_0000_0000 || overflow !== 1'b1 || cout !== 1'b0) begin
      errors++; $display("FAIL ovf64 res=%h o=%b c=%b required 8000000000000000 1 0", result, overflow, cout);
    end
    release_op();
    start_op(64'h7FFF, 64'd1, 1'b0, 1'b0, 1'b0, 2'b10);
    wait_done(lat, nlat);
    checks++;
    if (n_result !== 16'h8000 || n_overflow !== 1'b1 || n_cout !== 1'b0 || nlat != 1) begin
      errors++; $display("FAIL ovf16 res=%h o=%b c=%b lat=%0d required 8000 1 0 1", n_result, n_overflow, n_cout, nlat);
    end
    checks++;
    if (result !== 64'h8000 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf16_wide res=%h o=%b required 8000 0", result, overflow);
    end
    release_op();
  endtask

  task automatic test_logic();
    int lat, nlat;
    start_op(64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b1, 1'b0, 2'b00);
    wait_done(lat, nlat);
    checks++;
    if (result !== 64'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL nor res=%h z=%b required 0 1", result, zero);
    end
    release_op();
    start_op(64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0, 2'b01);
    wait_done(lat, nlat);
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFF || zero !== 1'b0) begin
      errors++; $display("FAIL or res=%h z=%b required ffffffffffffffff 0", result, zero);
    end
    release_op();
  endtask

  task automatic test_slt();
    int lat, nlat;
    logic [63:0] r1, r2;
    logic        z1, z2;
`ifdef ALU_SLT_EN
    r1 = 64'd1; z1 = 1'b0; r2 = 64'd0; z2 = 1'b1;
`else
    r1 = 64'hFFFF_FFFF_FFFF_FFFE; z1 = 1'b0; r2 = 64'd2; z2 = 1'b0;
`endif
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1, 2'b11);
    wait_done(lat, nlat);
    checks++;
    if (result !== r1 || zero !== z1) begin
      errors++; $display("FAIL slt_neg res=%h z=%b required %h %b", result, zero, r1, z1);
    end
    release_op();
    start_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 2'b11);
    wait_done(lat, nlat);
    checks++;
    if (result !== r2 || zero !== z2) begin
      errors++; $display("FAIL slt_pos res=%h z=%b required %h %b", result, zero, r2, z2);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat, nlat, late;
    logic [63:0] er;
    logic        ec, ez, eo;
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b1, 2'b10, er, ec, ez, eo);
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b1, 2'b10);
    wait_done(lat, nlat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || {cout, zero, overflow} !== {ec, ez, eo}) begin
        errors++;
        $display("FAIL hold_%0d vld=%b rdy=%b res=%h flags=%b%b%b required 1 0 %h %b%b%b",
                 i, out_valid, in_ready, result, cout, zero, overflow, er, ec, ez, eo);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    late = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL bp_no_second_op busy_cycles=%0d required 0", late); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    start_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0, 2'b10);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL mid_reset rdy=%b vld=%b res=%h required 1 0 0", in_ready, out_valid, result);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_no_result valid_cycles=%0d required 0", seen); end
  endtask

  task automatic test_random();
    int lat, nlat;
    logic [63:0] ta, tb, er;
    logic [1:0]  top;
    logic        ai, bi, ci, ec, ez, eo;
    for (int i = 0; i < 20; i++) begin
      ta = {$urandom(), $urandom()}; tb = {$urandom(), $urandom()};
      if (i % 5 == 1) tb = ~ta;
      if (i % 5 == 3) ta = 64'h8000_0000_0000_0000;
      ai = 1'($urandom()); bi = 1'($urandom()); ci = 1'($urandom()); top = 2'($urandom());
      model(ta, tb, ai, bi, ci, top, er, ec, ez, eo);
      start_op(ta, tb, ai, bi, ci, top);
      wait_done(lat, nlat);
      checks++;
      if (result !== er || lat != 8) begin
        errors++; $display("FAIL rand_%0d_result res=%h lat=%0d required %h 8", i, result, lat, er);
      end
      checks++;
      if ({cout, zero, overflow} !== {ec, ez, eo}) begin
        errors++; $display("FAIL rand_%0d_flags c=%b z=%b o=%b required %b %b %b", i, cout, zero, overflow, ec, ez, eo);
      end
      release_op();
    end
  endtask

  task automatic test_back_to_back();
    int          cyc = 0, issued = 0, got = 0;
    int          acc[$];
    logic [63:0] eq_r[$];
    logic [2:0]  eq_f[$];
    logic [63:0] ta, tb, er, xr;
    logic [2:0]  xf;
    logic        ec, ez, eo;
    out_ready = 1'b1;
    while ((issued < 4 || got < 4) && cyc < 200) begin
      @(negedge clk); cyc++;
      in_valid = 1'b0;
      if (out_valid && eq_r.size() > 0) begin
        xr = eq_r.pop_front(); xf = eq_f.pop_front(); got++;
        checks++;
        if (result !== xr || {cout, zero, overflow} !== xf) begin
          errors++; $display("FAIL b2b_%0d res=%h flags=%b%b%b required %h %b", got, result, cout, zero, overflow, xr, xf);
        end
      end
      if (in_ready && issued < 4) begin
        ta = {$urandom(), $urandom()}; tb = {$urandom(), $urandom()};
        a = ta; b = tb; ainv = 1'b0; binv = 1'($urandom()); cin = 1'($urandom()); op = 2'($urandom());
        model(ta, tb, 1'b0, binv, cin, op, er, ec, ez, eo);
        eq_r.push_back(er); eq_f.push_back({ec, ez, eo});
        acc.push_back(cyc); issued++; in_valid = 1'b1;
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL b2b_count got %0d required 4", got); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 10) begin
        errors++; $display("FAIL b2b_period_%0d got %0d required 10", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = 2'b00;
    test_reset();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_logic();
    test_slt();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
